// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - APB master state encoding, command layout and strobe-width helper
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    // Field order matches the flat queue word packed by the master: {write, addr, wdata, strb}
    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_W-1:0]     addr;
        logic [CMD_DATA_W-1:0]     wdata;
        logic [CMD_DATA_W/8-1:0]   strb;
    } apb_cmd_t;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - Show-ahead command queue exposing the head and the entry behind it
module apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic             full,
    output logic             empty,
    output logic [W-1:0]     head,
    output logic [W-1:0]     head2,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + PTR_W'(1);
    assign head      = mem[rd_ptr];
    assign head2     = mem[rd_ptr_nx];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr_nx;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_master_q.sv
// rtl/apb_master_q.sv - Queued APB4 master; defining APB_TIMEOUT_EN adds the ACCESS wait abort
module apb_master_q
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_tout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);
    localparam int STRB_W = strb_width(DATA_W);
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    apb_state_t         state;
    logic [CMD_W-1:0]   req_cmd;
    logic [CMD_W-1:0]   head;
    logic [CMD_W-1:0]   head2;
    logic [CMD_W-1:0]   load_cmd;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   cnt_next;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               done;
    logic               tout_hit;
    logic               more;
    logic               ld_write;
    logic [ADDR_W-1:0]  ld_addr;
    logic [DATA_W-1:0]  ld_wdata;
    logic [STRB_W-1:0]  ld_strb;

    assign req_cmd  = {req_write, req_addr, req_wdata, req_strb};
    assign push     = req_valid && req_ready && !full;
    assign done     = (state == ACCESS) && PREADY;
    assign pop      = done || tout_hit;
    assign cnt_next = count + CNT_W'(push) - CNT_W'(pop);
    assign more     = (cnt_next != '0);

    // On a pop the next transfer is the stored entry behind the head, or the request arriving now
    assign load_cmd = (state != ACCESS)      ? head  :
                      (count > CNT_W'(1))    ? head2 : req_cmd;
    assign {ld_write, ld_addr, ld_wdata, ld_strb} = load_cmd;

    apb_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .push   (push),
        .pop    (pop),
        .wdata  (req_cmd),
        .full   (full),
        .empty  (empty),
        .head   (head),
        .head2  (head2),
        .count  (count)
    );

`ifdef APB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              tout_q;

    assign tout_hit = (state == ACCESS) && !PREADY && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign rsp_tout = tout_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
            tout_q   <= 1'b0;
        end else begin
            if (state == SETUP)
                wait_cnt <= '0;
            else if ((state == ACCESS) && !PREADY)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (done)
                tout_q <= 1'b0;
            else if (tout_hit)
                tout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign tout_hit       = 1'b0;
    assign rsp_tout       = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (cnt_next != CNT_W'(DEPTH));
            rsp_valid <= pop;
            if (done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (tout_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= ld_write;
                        PADDR   <= ld_addr;
                        PWDATA  <= ld_wdata;
                        PSTRB   <= ld_write ? ld_strb : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (pop) begin
                        PENABLE <= 1'b0;
                        if (more) begin
                            state  <= SETUP;
                            PWRITE <= ld_write;
                            PADDR  <= ld_addr;
                            PWDATA <= ld_wdata;
                            PSTRB  <= ld_write ? ld_strb : '0;
                        end else begin
                            state <= IDLE;
                            PSEL  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_q.sv
// tb/tb_apb_master_q.sv - Directed self-checking bench for apb_master_q
module tb_apb_master_q;
    import apb_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        auto_mode = 1'b0;
    logic        err_on_write = 1'b0;
    logic [31:0] prdata_drv = 32'h0;
    logic        slverr_drv = 1'b0;

    apb_master_q dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_tout  (rsp_tout),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: either echoes a function of PADDR or returns directly driven values
    always_comb begin
        if (auto_mode) begin
            PRDATA  = PADDR ^ K;
            PSLVERR = err_on_write & PWRITE;
        end else begin
            PRDATA  = prdata_drv;
            PSLVERR = slverr_drv;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic apb_cmd_t mk(input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
        apb_cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        c.strb  = s;
        return c;
    endfunction

    task automatic drive(input apb_cmd_t c);
        req_valid = 1'b1;
        req_write = c.write;
        req_addr  = c.addr;
        req_wdata = c.wdata;
        req_strb  = c.strb;
    endtask

    task automatic push_cmd(input apb_cmd_t c);
        int n = 0;
        drive(c);
        while (!req_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("push_accept", (n < 50), 1);
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output logic [31:0] rd, output logic err);
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!rsp_valid && n < 40);
        check(tag, rsp_valid, 1);
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd1, rd2;
        logic        err1, err2;
        int          acc, k, nrsp, gaps, pend;
        logic [31:0] got [5];

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        PREADY    = 1'b0;
        repeat (2) @(negedge PCLK);

        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_rsp_tout", rsp_tout, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("ready_after_rst", req_ready, 1);

        // single write, zero-wait slave
        PREADY = 1'b1;
        drive(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
        @(negedge PCLK);
        req_valid = 1'b0;
        check("t1_idle_psel", PSEL, 0);
        @(negedge PCLK);
        check("t1_setup_psel", PSEL, 1);
        check("t1_setup_penable", PENABLE, 0);
        check("t1_setup_paddr", PADDR, 32'h10);
        check("t1_setup_pwdata", PWDATA, 32'hDEADBEEF);
        check("t1_setup_pstrb", PSTRB, 4'hF);
        check("t1_setup_pwrite", PWRITE, 1);
        @(negedge PCLK);
        check("t1_access_psel", PSEL, 1);
        check("t1_access_penable", PENABLE, 1);
        @(negedge PCLK);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_rdata", rsp_rdata, 0);
        check("t1_idle_after", PSEL, 0);
        @(negedge PCLK);
        check("t1_rsp_pulse", rsp_valid, 0);

        // read with three wait states; junk PRDATA/PSLVERR while not ready
        PREADY     = 1'b0;
        prdata_drv = 32'hBAD0BAD0;
        slverr_drv = 1'b1;
        drive(mk(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF));
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t2_setup_pstrb", PSTRB, 0);
        check("t2_setup_pwrite", PWRITE, 0);
        check("t2_setup_penable", PENABLE, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("t2_wait_penable", PENABLE, 1);
            check("t2_wait_paddr", PADDR, 32'h20);
            check("t2_wait_no_rsp", rsp_valid, 0);
        end
        PREADY     = 1'b1;
        prdata_drv = 32'h12345678;
        slverr_drv = 1'b0;
        @(negedge PCLK);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_rdata", rsp_rdata, 32'h12345678);
        check("t2_rsp_err", rsp_err, 0);
        check("t2_idle_after", PSEL, 0);

        // fill the queue, then drain back-to-back
        PREADY    = 1'b0;
        auto_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_ready_open", req_ready, 1);
            drive(mk(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF));
            @(negedge PCLK);
        end
        check("t3_ready_full", req_ready, 0);
        drive(mk(1'b0, 32'h110, 32'h0, 4'hF));
        repeat (2) @(negedge PCLK);
        check("t3_ready_held", req_ready, 0);
        PREADY = 1'b1;
        nrsp = 0; gaps = 0; k = 0; pend = 0;
        while (nrsp < 5 && k < 40) begin
            @(negedge PCLK);
            k++;
            if (pend != 0) begin
                req_valid = 1'b0;
                pend = 0;
            end else if (req_valid && req_ready) begin
                pend = 1;
            end
            if (rsp_valid) begin
                got[nrsp] = rsp_rdata;
                nrsp++;
            end
            if (nrsp < 5 && !PSEL) gaps++;
        end
        check("t3_rsp_count", nrsp, 5);
        check("t3_drain_cycles", k, 9);
        check("t3_idle_gaps", gaps, 0);
        for (int i = 0; i < 5; i++)
            check("t3_rsp_order", got[i], (32'h100 + 32'(4 * i)) ^ K);

        // slave error on a write, then a clean read
        err_on_write = 1'b1;
        push_cmd(mk(1'b1, 32'h30, 32'h55AA55AA, 4'h3));
        push_cmd(mk(1'b0, 32'h34, 32'h0, 4'hF));
        wait_rsp("t4_wr_rsp", rd1, err1);
        wait_rsp("t4_rd_rsp", rd2, err2);
        check("t4_wr_err", err1, 1);
        check("t4_wr_rdata", rd1, 0);
        check("t4_rd_err", err2, 0);
        check("t4_rd_rdata", rd2, 32'h34 ^ K);
        err_on_write = 1'b0;
        auto_mode    = 1'b0;

        // reset during ACCESS with two more entries queued
        PREADY = 1'b0;
        push_cmd(mk(1'b1, 32'h50, 32'h1, 4'hF));
        push_cmd(mk(1'b1, 32'h54, 32'h2, 4'hF));
        push_cmd(mk(1'b0, 32'h58, 32'h0, 4'hF));
        check("t5_in_access", PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        check("t5_psel_drop", PSEL, 0);
        check("t5_penable_drop", PENABLE, 0);
        check("t5_rsp_quiet", rsp_valid, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        nrsp = 0; acc = 0;
        repeat (8) begin
            @(negedge PCLK);
            if (rsp_valid) nrsp++;
            if (PSEL) acc++;
        end
        check("t5_no_rsp", nrsp, 0);
        check("t5_stays_idle", acc, 0);
        check("t5_ready", req_ready, 1);

        // slave never ready
        PREADY = 1'b0;
        push_cmd(mk(1'b0, 32'h40, 32'h0, 4'hF));
        acc = 0; k = 0; nrsp = 0;
`ifdef APB_TIMEOUT_EN
        while (!rsp_valid && k < 120) begin
            @(negedge PCLK);
            k++;
            if (PSEL && PENABLE) acc++;
        end
        check("t6_tout_rsp", rsp_valid, 1);
        check("t6_access_cycles", acc, 16);
        check("t6_tout_err", rsp_err, 1);
        check("t6_tout_flag", rsp_tout, 1);
        check("t6_tout_rdata", rsp_rdata, 0);
`else
        repeat (100) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) acc++;
            if (rsp_valid) nrsp++;
        end
        check("t6_access_cycles", acc, 99);
        check("t6_no_rsp", nrsp, 0);
        check("t6_still_access", PENABLE, 1);
        check("t6_tout_tied", rsp_tout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
